// File: rtl/softmax_norm_vec_if.sv
// softmax_norm_vec_if: tile-stream bundle for the softmax normalizer.
//   in_valid/in_ready/in_data    : exp tiles in (element 0 in the MS chunk)
//   out_valid/out_ready/out_data : normalized tiles out
//   out_last                     : final tile of a row
//   err_zero                     : the current row sum is zero
// slave is the normalizer's view; master is the producer/consumer side.
interface softmax_norm_vec_if #(
  parameter int WIDTH     = 32,
  parameter int TILE_SIZE = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [TILE_SIZE*WIDTH-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [TILE_SIZE*WIDTH-1:0] out_data;
  logic                       out_last;
  logic                       err_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, err_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_zero
  );
endinterface

// File: rtl/softmax_norm_vec.sv
// softmax_norm_vec: buffers one softmax row of ROW_TILES exp tiles, sums
// them, computes R = floor(2^(2*FRAC)/S) with a bit-serial restoring
// divider, then streams every buffered tile back out scaled by R.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : softmax_norm_vec_if.slave (tile in/out handshakes, out_last,
//           err_zero)
// Build option: define SOFTMAX_NORM_ROUND_EN to round half-up before the
// >>FRAC scaling shift; otherwise the product is truncated.
module softmax_norm_vec #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int TILE_SIZE = 4,
  parameter int ROW_TILES = 4
) (
  input logic              CLK,
  input logic              RST_N,
  softmax_norm_vec_if.slave bus
);

  localparam int TW   = TILE_SIZE * WIDTH;
  localparam int SUMW = WIDTH + $clog2(TILE_SIZE * ROW_TILES);
  localparam int QW   = 2 * FRAC + 1;
  localparam int CW   = (QW > WIDTH) ? QW : WIDTH;
  localparam int CNTW = $clog2(2 * FRAC + 2) + 1;
  localparam int IDXW = $clog2(ROW_TILES + 1);
  localparam int AW   = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;

  localparam logic [WIDTH-1:0]   RMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] ONE_W = {{(2*WIDTH-1){1'b0}}, 1'b1} << FRAC;
`ifdef SOFTMAX_NORM_ROUND_EN
  localparam logic [2*WIDTH-1:0] RND_W = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC - 1);
`else
  localparam logic [2*WIDTH-1:0] RND_W = '0;
`endif

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DIV   = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  logic [1:0]      state_q;
  logic [SUMW-1:0] sum_q;
  logic [WIDTH-1:0] r_q;
  logic [SUMW-1:0] rem_q;
  logic [QW-2:0]   quo_q;
  logic [CNTW-1:0] cnt_q;
  logic [IDXW-1:0] wr_idx_q;
  logic [IDXW-1:0] rd_idx_q;
  logic            out_valid_q;
  logic [TW-1:0]   out_data_q;
  logic            out_last_q;
  logic            err_zero_q;
  logic [TW-1:0]   buf_q [ROW_TILES];

  logic            accept;
  logic [TW-1:0]   in_clamped;
  logic [SUMW-1:0] tile_sum;
  logic [WIDTH-1:0] in_elem;

  logic            div_bit;
  logic [SUMW:0]   rem_shift;
  logic            div_ge;
  logic [SUMW-1:0] rem_next;
  logic [QW-1:0]   quo_next;
  logic [CW-1:0]   quo_ext;
  logic [WIDTH-1:0] r_fin;

  logic            load;
  logic            out_hs;
  logic [TW-1:0]   src_tile;
  logic [TW-1:0]   scaled;
  logic [WIDTH-1:0] x_elem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] shifted;

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_zero  = err_zero_q;

  assign accept = (state_q == ST_ACCUM) && bus.in_valid;
  assign out_hs = out_valid_q && bus.out_ready;
  assign load   = (state_q == ST_EMIT) && (rd_idx_q < IDXW'(ROW_TILES)) &&
                  (!out_valid_q || bus.out_ready);

  // Negative exp values are clamped to zero before buffering and summing.
  always_comb begin
    in_clamped = '0;
    tile_sum   = '0;
    in_elem    = '0;
    for (int unsigned j = 0; j < TILE_SIZE; j++) begin
      in_elem = bus.in_data[(TILE_SIZE-1-j)*WIDTH +: WIDTH];
      if (!in_elem[WIDTH-1]) begin
        in_clamped[(TILE_SIZE-1-j)*WIDTH +: WIDTH] = in_elem;
        tile_sum = tile_sum + SUMW'(in_elem);
      end
    end
  end

  // Restoring divider step. The dividend 2^(2*FRAC) has only its MSB set,
  // so the incoming dividend bit is 1 on the first iteration only.
  always_comb begin
    div_bit   = (cnt_q == CNTW'(1));
    rem_shift = {rem_q, div_bit};
    div_ge    = (rem_shift >= {1'b0, sum_q});
    rem_next  = div_ge ? SUMW'(rem_shift - {1'b0, sum_q}) : rem_shift[SUMW-1:0];
    quo_next  = {quo_q, div_ge};
    quo_ext   = CW'(quo_next);
    r_fin     = ((sum_q == '0) || (quo_ext > CW'(RMAX))) ? RMAX : WIDTH'(quo_ext);
  end

  // Scale the slot about to be loaded into the output register.
  always_comb begin
    src_tile = buf_q[rd_idx_q[AW-1:0]];
    scaled   = '0;
    x_elem   = '0;
    prod     = '0;
    shifted  = '0;
    for (int unsigned j = 0; j < TILE_SIZE; j++) begin
      x_elem  = src_tile[(TILE_SIZE-1-j)*WIDTH +: WIDTH];
      prod    = ((2*WIDTH)'(x_elem) * (2*WIDTH)'(r_q)) + RND_W;
      shifted = prod >> FRAC;
      scaled[(TILE_SIZE-1-j)*WIDTH +: WIDTH] =
        (shifted > ONE_W) ? ONE_W[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      buf_q[wr_idx_q[AW-1:0]] <= in_clamped;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_ACCUM;
      sum_q       <= '0;
      r_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            sum_q    <= sum_q + tile_sum;
            wr_idx_q <= wr_idx_q + IDXW'(1);
            if (wr_idx_q == IDXW'(ROW_TILES - 1)) begin
              state_q <= ST_DIV;
              cnt_q   <= '0;
            end
          end
        end
        ST_DIV: begin
          // cnt 0 initialises the divider; cnt 1..QW are the quotient bits.
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == '0) begin
            rem_q      <= '0;
            quo_q      <= '0;
            err_zero_q <= (sum_q == '0);
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next[QW-2:0];
            if (cnt_q == CNTW'(QW)) begin
              r_q     <= r_fin;
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= scaled;
            out_last_q  <= (rd_idx_q == IDXW'(ROW_TILES - 1));
            rd_idx_q    <= rd_idx_q + IDXW'(1);
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (out_hs && out_last_q) begin
            state_q    <= ST_ACCUM;
            sum_q      <= '0;
            r_q        <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            err_zero_q <= 1'b0;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule
